// File: rtl/fractal_pkg.sv
// Shared types for the fractal pipeline: Q4.28 fixed-point values, iteration
// counts and the result record handed downstream.
package fractal_pkg;

    localparam int FIXED_WIDTH = 32;
    localparam int ITER_WIDTH  = 8;

    typedef logic signed [FIXED_WIDTH-1:0] fixed_t;
    typedef logic [ITER_WIDTH-1:0]         iter_t;

    // An escape count equal to MAX_ITER means the point never escaped.
    localparam iter_t MAX_ITER = 8'd255;

    typedef struct packed {
        fixed_t cr;
        fixed_t ci;
        iter_t  iter;
    } result_t;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO for finished results. The head entry is presented
// combinationally so a retire shows up as out_valid one cycle later.
module result_fifo
    import fractal_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = result_t
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    output entry_t                 pop_data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // Push is judged against the registered count, never against a same-cycle pop.
    assign do_push = push_i && (count_q != (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data_o = mem[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/fractal_dispatcher.sv
// Slot controller around the fractal kernel ring: injects new pixels into free
// slots, recirculates unfinished ones and retires finished ones to a result FIFO.
module fractal_dispatcher
    import fractal_pkg::*;
#(
    parameter int DATA_WIDTH     = FIXED_WIDTH,
    parameter int RING_LATENCY   = 8,
    parameter int OUT_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_cr,
    input  logic [DATA_WIDTH-1:0] in_ci,
    output logic [DATA_WIDTH-1:0] k_zr,
    output logic [DATA_WIDTH-1:0] k_zi,
    output logic [DATA_WIDTH-1:0] k_cr,
    output logic [DATA_WIDTH-1:0] k_ci,
    output logic [7:0]            k_iter,
    output logic                  k_finished,
    output logic                  k_inc_enabled,
    input  logic [DATA_WIDTH-1:0] r_zr,
    input  logic [DATA_WIDTH-1:0] r_zi,
    input  logic [DATA_WIDTH-1:0] r_cr,
    input  logic [DATA_WIDTH-1:0] r_ci,
    input  logic [7:0]            r_iter,
    input  logic                  r_finished,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_cr,
    output logic [DATA_WIDTH-1:0] out_ci,
    output logic [7:0]            out_iter,
    output logic                  busy
);

    localparam int CNT_W = $clog2(OUT_FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] cr;
        logic [DATA_WIDTH-1:0] ci;
        iter_t                 iter;
    } entry_t;

    // Occupancy travels alongside the kernel data; the kernel itself has no valid.
    logic [RING_LATENCY-1:0] tag_q;
    logic                    tag_d;

    logic [DATA_WIDTH-1:0] k_zr_q, k_zr_d;
    logic [DATA_WIDTH-1:0] k_zi_q, k_zi_d;
    logic [DATA_WIDTH-1:0] k_cr_q, k_cr_d;
    logic [DATA_WIDTH-1:0] k_ci_q, k_ci_d;
    iter_t                 k_iter_q, k_iter_d;
    logic                  k_fin_q, k_fin_d;
    logic                  k_inc_q, k_inc_d;

    logic             ret_occ;
    logic             fifo_full;
    logic             retire;
    logic             slot_free;
    logic             fifo_pop;
    logic [CNT_W-1:0] fifo_count;
    entry_t           push_entry;
    entry_t           head_entry;

    assign ret_occ   = tag_q[RING_LATENCY-1];
    assign fifo_full = (fifo_count == CNT_W'(OUT_FIFO_DEPTH));
    assign retire    = ret_occ && r_finished && !fifo_full;
    assign slot_free = !ret_occ || retire;
    assign in_ready  = resetn && slot_free;

    always_comb begin
        tag_d    = 1'b0;
        k_zr_d   = '0;
        k_zi_d   = '0;
        k_cr_d   = '0;
        k_ci_d   = '0;
        k_iter_d = '0;
        k_fin_d  = 1'b1;
        k_inc_d  = 1'b0;
        if (ret_occ && !retire) begin
            // Recirculate; a finished slot waiting on a full FIFO keeps finished=1.
            tag_d    = 1'b1;
            k_zr_d   = r_zr;
            k_zi_d   = r_zi;
            k_cr_d   = r_cr;
            k_ci_d   = r_ci;
            k_iter_d = r_iter;
            k_fin_d  = r_finished;
            k_inc_d  = 1'b1;
        end else if (in_valid) begin
            tag_d    = 1'b1;
            k_cr_d   = in_cr;
            k_ci_d   = in_ci;
            k_fin_d  = 1'b0;
            k_inc_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_q    <= '0;
            k_zr_q   <= '0;
            k_zi_q   <= '0;
            k_cr_q   <= '0;
            k_ci_q   <= '0;
            k_iter_q <= '0;
            k_fin_q  <= 1'b1;
            k_inc_q  <= 1'b0;
        end else begin
            tag_q    <= {tag_q[RING_LATENCY-2:0], tag_d};
            k_zr_q   <= k_zr_d;
            k_zi_q   <= k_zi_d;
            k_cr_q   <= k_cr_d;
            k_ci_q   <= k_ci_d;
            k_iter_q <= k_iter_d;
            k_fin_q  <= k_fin_d;
            k_inc_q  <= k_inc_d;
        end
    end

    assign k_zr          = k_zr_q;
    assign k_zi          = k_zi_q;
    assign k_cr          = k_cr_q;
    assign k_ci          = k_ci_q;
    assign k_iter        = k_iter_q;
    assign k_finished    = k_fin_q;
    assign k_inc_enabled = k_inc_q;

    assign push_entry = '{cr: r_cr, ci: r_ci, iter: r_iter};

    result_fifo #(
        .DEPTH   (OUT_FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_result_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (retire),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_entry),
        .count_o     (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign fifo_pop  = out_valid && out_ready;
    assign out_cr    = head_entry.cr;
    assign out_ci    = head_entry.ci;
    assign out_iter  = head_entry.iter;
    assign busy      = (|tag_q) || out_valid;

endmodule

// File: tb/tb_fractal_dispatcher.sv
// Directed bench: dispatcher closed around a behavioural Mandelbrot kernel ring.
module tb_fractal_dispatcher;
    import fractal_pkg::*;

    localparam int DW = 32;
    localparam int L  = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_cr, in_ci;
    logic [DW-1:0] k_zr, k_zi, k_cr, k_ci;
    logic [7:0]    k_iter;
    logic          k_finished, k_inc_enabled;
    logic [DW-1:0] r_zr, r_zi, r_cr, r_ci;
    logic [7:0]    r_iter;
    logic          r_finished;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_cr, out_ci;
    logic [7:0]    out_iter;
    logic          busy;

    always #5 clk = ~clk;

    fractal_dispatcher #(
        .DATA_WIDTH     (DW),
        .RING_LATENCY   (L),
        .OUT_FIFO_DEPTH (FD)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_cr         (in_cr),
        .in_ci         (in_ci),
        .k_zr          (k_zr),
        .k_zi          (k_zi),
        .k_cr          (k_cr),
        .k_ci          (k_ci),
        .k_iter        (k_iter),
        .k_finished    (k_finished),
        .k_inc_enabled (k_inc_enabled),
        .r_zr          (r_zr),
        .r_zi          (r_zi),
        .r_cr          (r_cr),
        .r_ci          (r_ci),
        .r_iter        (r_iter),
        .r_finished    (r_finished),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_cr        (out_cr),
        .out_ci        (out_ci),
        .out_iter      (out_iter),
        .busy          (busy)
    );

    // Kernel ring model: one Mandelbrot step, then L-1 register stages, so the
    // k_* register plus these stages make L slots.
    typedef struct packed {
        logic signed [31:0] zr;
        logic signed [31:0] zi;
        logic signed [31:0] cr;
        logic signed [31:0] ci;
        logic [7:0]         iter;
        logic               fin;
        logic               occ;
    } kst_t;

    kst_t stg [L-1];
    kst_t k_in, r_out;

    function automatic kst_t kstep(input kst_t a);
        kst_t   b;
        longint zr, zi, mag;
        b = a;
        if (a.occ && !a.fin) begin
            zr     = longint'(a.zr);
            zi     = longint'(a.zi);
            mag    = zr * zr + zi * zi;
            b.iter = a.iter + 8'd1;
            if (mag > (64'sd4 <<< 56) || b.iter == 8'd255) begin
                b.fin = 1'b1;
            end else begin
                b.zr = int'((zr * zr - zi * zi) >>> 28) + a.cr;
                b.zi = int'((2 * zr * zi) >>> 28) + a.ci;
            end
        end
        return b;
    endfunction

    assign k_in = {k_zr, k_zi, k_cr, k_ci, k_iter, k_finished, k_inc_enabled};

    always @(posedge clk) begin
        stg[0] <= kstep(k_in);
        for (int i = 1; i < L - 1; i++) stg[i] <= stg[i-1];
    end

    assign r_out      = stg[L-2];
    assign r_zr       = r_out.zr;
    assign r_zi       = r_out.zi;
    assign r_cr       = r_out.cr;
    assign r_ci       = r_out.ci;
    assign r_iter     = r_out.iter;
    assign r_finished = r_out.fin;

    // Result collector and cycle monitors, sampled just after the falling edge.
    logic [31:0] res_cr [$];
    logic [31:0] res_ci [$];
    logic [7:0]  res_it [$];
    int          ring_full_cycles = 0;
    int          ring_full_viol   = 0;
    int          hold_cycles      = 0;
    int          stall_viol       = 0;
    logic        prev_stall       = 1'b0;
    logic [71:0] prev_out         = '0;

    always @(negedge clk) begin
        int occ;
        #1;
        if (resetn) begin
            occ = int'(k_inc_enabled);
            for (int i = 0; i < L - 1; i++) occ += int'(stg[i].occ);
            if (occ == L) begin
                ring_full_cycles++;
                if (!r_out.fin && in_ready) ring_full_viol++;
            end
            if (k_finished && k_inc_enabled) hold_cycles++;
            if (prev_stall && ({out_cr, out_ci, out_iter} != prev_out)) stall_viol++;
            if (out_valid && out_ready) begin
                res_cr.push_back(out_cr);
                res_ci.push_back(out_ci);
                res_it.push_back(out_iter);
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_cr, out_ci, out_iter};
        end else begin
            prev_stall = 1'b0;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the handshake.
    task automatic send(input logic [31:0] cr, input logic [31:0] ci);
        int guard = 0;
        in_cr    = cr;
        in_ci    = ci;
        in_valid = 1'b1;
        while (!in_ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("send accepted", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget);
        int cyc = 0;
        while (res_cr.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_tag(input string tag, input int base, input logic [31:0] cr,
                             input logic [31:0] ci, input logic [7:0] it);
        int         n   = 0;
        logic [7:0] got = 8'h00;
        for (int i = base; i < res_cr.size(); i++) begin
            if (res_cr[i] == cr && res_ci[i] == ci) begin
                n++;
                got = res_it[i];
            end
        end
        $display("[TB] %s cr=0x%08h ci=0x%08h seen=%0d iter=%0d", tag, cr, ci, n, got);
        check({tag, " count"}, n, 1);
        check({tag, " iter"}, got, it);
    endtask

    initial begin
        int base;
        int snap;
        in_valid  = 1'b0;
        in_cr     = '0;
        in_ci     = '0;
        out_ready = 1'b1;
        resetn    = 1'b0;
        repeat (L + 2) @(negedge clk);

        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset in_ready", in_ready, 0);
        check("reset k_finished", k_finished, 1);
        check("reset k_inc_enabled", k_inc_enabled, 0);
        check("reset k_zr", k_zr, 0);
        check("reset k_iter", k_iter, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle in_ready", in_ready, 1);

        // Single c=2.0 pixel: three laps, retire at 3*L, out_valid one cycle later.
        send(32'h2000_0000, 32'h0);
        check("inject k_cr", k_cr, 32'h2000_0000);
        check("inject k_zr", k_zr, 0);
        check("inject k_finished", k_finished, 0);
        check("inject k_inc_enabled", k_inc_enabled, 1);
        repeat (3 * L - 1) @(negedge clk);
        check("t1 out_valid before retire", out_valid, 0);
        @(negedge clk);
        check("t1 out_valid", out_valid, 1);
        check("t1 out_iter", out_iter, 3);
        check("t1 out_cr", out_cr, 32'h2000_0000);
        check("t1 out_ci", out_ci, 0);
        repeat (2) @(negedge clk);
        check("t1 result count", res_cr.size(), 1);
        check("t1 busy after", busy, 0);

        // c=0 never escapes: result after 255 laps with iter 255.
        base = res_cr.size();
        send(32'h0, 32'h0);
        wait_results(base + 1, 255 * L + 50);
        check("t2 result count", res_cr.size() - base, 1);
        check_tag("t2 c=0", base, 32'h0, 32'h0, 8'd255);
        repeat (3) @(negedge clk);
        check("t2 busy after", busy, 0);

        // 20 fast pixels streamed; ring saturates and must hold off input.
        base = res_cr.size();
        snap = ring_full_cycles;
        for (int k = 1; k <= 20; k++) send(32'h2000_0000 - k, 32'h0);
        wait_results(base + 20, 600);
        check("t3 result count", res_cr.size() - base, 20);
        for (int k = 1; k <= 20; k++) check_tag("t3 pixel", base, 32'h2000_0000 - k, 32'h0, 8'd3);
        check("t3 ring reached full", ring_full_cycles > snap, 1);
        check("t3 in_ready low on full ring", ring_full_viol, 0);

        // Downstream stalled: 4 results parked in FIFO, 6 slots held in the ring.
        base      = res_cr.size();
        snap      = hold_cycles;
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) send(32'h2000_0000 - 100 - k, 32'h0);
        repeat (60) @(negedge clk);
        check("t4 nothing delivered while stalled", res_cr.size() - base, 0);
        check("t4 out_valid while stalled", out_valid, 1);
        check("t4 busy while stalled", busy, 1);
        check("t4 held slots recirculate", hold_cycles > snap, 1);
        check("t4 out stable while stalled", stall_viol, 0);
        out_ready = 1'b1;
        wait_results(base + 10, 300);
        repeat (40) @(negedge clk);
        check("t4 result count", res_cr.size() - base, 10);
        for (int k = 1; k <= 10; k++) check_tag("t4 pixel", base, 32'h2000_0000 - 100 - k, 32'h0, 8'd3);
        check("t4 busy after drain", busy, 0);

        // Slow (inside set) and fast pixels interleaved: fast ones overtake.
        base = res_cr.size();
        for (int k = 1; k <= 4; k++) begin
            send(32'h0, 32'(k));
            send(32'h2000_0000 - 200 - k, 32'h0);
        end
        wait_results(base + 8, 255 * L + 100);
        check("t5 result count", res_cr.size() - base, 8);
        for (int i = 0; i < 4; i++) check("t5 fast first", (base + i < res_it.size()) ? res_it[base + i] : 8'h00, 3);
        for (int k = 1; k <= 4; k++) begin
            check_tag("t5 slow", base, 32'h0, 32'(k), 8'd255);
            check_tag("t5 fast", base, 32'h2000_0000 - 200 - k, 32'h0, 8'd3);
        end

        // Reset mid-run discards ring and FIFO contents.
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) send(32'h2000_0000 - 300 - k, 32'h0);
        repeat (30) @(negedge clk);
        check("t6 out_valid before reset", out_valid, 1);
        resetn = 1'b0;
        #1;
        check("t6 reset out_valid", out_valid, 0);
        check("t6 reset busy", busy, 0);
        check("t6 reset k_finished", k_finished, 1);
        check("t6 reset k_inc_enabled", k_inc_enabled, 0);
        check("t6 reset in_ready", in_ready, 0);
        repeat (L + 2) @(negedge clk);
        base      = res_cr.size();
        resetn    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        send(32'h2000_0000, 32'h0);
        wait_results(base + 1, 100);
        repeat (40) @(negedge clk);
        check("t6 result count after reset", res_cr.size() - base, 1);
        check_tag("t6 new pixel", base, 32'h2000_0000, 32'h0, 8'd3);
        check("t6 out stable overall", stall_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fractal_dispatcher.md
# fractal_dispatcher

Slot controller closing the loop around a chain of `fractal_kernel` stages. It injects new pixel constants `c` into free pipeline slots and recirculates unfinished slots back to the chain head. It retires finished slots into a small output FIFO that drives a valid/ready result stream. It sits between the coordinate generator (upstream) and the colour mapper (downstream), and is the only producer of kernel inputs and the only consumer of kernel outputs.

## Interface
- `DATA_WIDTH`, 32: width of z/c, signed Q4.28.
- `RING_LATENCY`, 8: cycles from `k_*` register update to matching `r_*` sample; equals the summed kernel `PIPELINE_DEPTH`; ≥ 2.
- `OUT_FIFO_DEPTH`, 4: result FIFO entries; power of two, ≥ 2.
- Reset: single clock, reset asynchronous and active-low.
- `clk` in 1: sole clock.
- `resetn` in 1: asynchronous active-low reset.
- `in_valid` / `in_ready` in/out 1: pixel input handshake.
- `in_cr`, `in_ci` in DATA_WIDTH: pixel constant c.
- `k_zr`, `k_zi`, `k_cr`, `k_ci` out DATA_WIDTH: chain head inputs (registered).
- `k_iter` out 8: iteration count to chain head.
- `k_finished` out 1: finished flag to chain head.
- `k_inc_enabled` out 1: `inc_enabled` to chain head; 1 only for occupied slots.
- `r_zr`, `r_zi`, `r_cr`, `r_ci` in DATA_WIDTH: chain tail outputs.
- `r_iter` in 8: chain tail iteration count.
- `r_finished` in 1: chain tail finished flag.
- `out_valid` / `out_ready` out/in 1: result handshake.
- `out_cr`, `out_ci` out DATA_WIDTH: tag of the result.
- `out_iter` out 8: escape iteration (255 = did not escape).
- `busy` out 1: any slot occupied or FIFO non-empty.

## Operation
- Slot tag shift register, RING_LATENCY bits: bit pushed with each `k_*` update, popped aligned with `r_*`. Kernel carries no valid, so this register is the sole occupancy record.
- Each cycle the returning slot `ret_occ` is decided, in priority order:
  - Retire: `ret_occ && r_finished && fifo_count < OUT_FIFO_DEPTH` → push {`r_cr`, `r_ci`, `r_iter`} to FIFO; slot becomes free.
  - Hold: `ret_occ && r_finished` and FIFO full → recirculate unchanged with `k_finished=1`; iter frozen by kernel.
  - Recirculate: `ret_occ && !r_finished` → `k_*` = `r_*`, `k_finished=0`, `k_inc_enabled=1`.
  - Inject: slot free (empty or retired this cycle) and `in_valid` → `k_zr=k_zi=0`, `k_cr/k_ci=in_*`, `k_iter=0`, `k_finished=0`, `k_inc_enabled=1`, tag 1.
  - Bubble: otherwise → tag 0, `k_finished=1`, `k_inc_enabled=0`, data zero.
- `in_ready` = slot free this cycle (combinational from tag tail, `r_finished`, registered `fifo_count`); never depends on `out_ready`.
- FIFO: simultaneous push and pop allowed when full-before-pop is false; count uses registered value only, so retire does not rely on same-cycle pop.
- Results are out of order; `out_cr/out_ci` identify the pixel.

## Timing
- Reset values: all `k_*` data 0, `k_finished` 1, `k_inc_enabled` 0, tags 0, FIFO empty, `out_valid` 0, `busy` 0, `in_ready` 0 while `resetn` low.
- Inject→first return: RING_LATENCY cycles. Retire→`out_valid`: 1 cycle.
- At most RING_LATENCY pixels in flight. Ring full and none finishing → `in_ready` 0.
- `out_*` stable while `out_valid && !out_ready`.
- Reset mid-operation: in-flight pixels and FIFO contents discarded; upstream must resend.

## Structure
- Package `fractal_pkg`: `fixed_t` (DATA_WIDTH signed), `iter_t` (8 bit), `MAX_ITER=255`, struct `result_t` {cr, ci, iter}.
- Sub-module `result_fifo` (synchronous FIFO of `result_t`, count output).
- Bench instantiates dispatcher + one `fractal_kernel` (PIPELINE_DEPTH = RING_LATENCY).

## Test plan
- Single pixel c=0x2000_0000+0i, out_ready=1 → exactly one result, iter=3, cr=0x2000_0000, `busy` drops after.
- c=0+0i → result iter=255 after 255 laps (~255·RING_LATENCY cycles).
- 20 pixels c=2.0 streamed, out_ready=1 → 20 results, each iter=3, `in_ready` low whenever 8 slots are occupied.
- out_ready=0, 10 pixels c=2.0 → FIFO holds 4, 6 held slots recirculate with iter 3. Release out_ready → all 10 delivered with iter=3 and none duplicated.
- Mixed c=0 and c=2.0 interleaved → fast pixels overtake slow ones; result set matches the sent set by tag.
- resetn low mid-run → next cycle `out_valid`=0, `busy`=0, `k_finished`=1. After release, a new pixel c=2.0 yields iter=3.
